// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: fetch PC plus a 2-entry {pc, instr} buffer feeding decode.
// Optional stall counter output is compiled in when FETCH_PERF_EN is defined.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } count_e;

  count_e      r_state, w_state_next;
  logic [31:0] r_fpc, w_fpc_next;
  logic [31:0] r_pc    [2];
  logic [31:0] r_instr [2];
  logic        w_pop, w_push, w_wr_slot;
  logic [1:0]  w_unused_rpc;

  assign w_unused_rpc = redirect_pc[1:0];

  always_comb begin
    w_pop        = (r_state != EMPTY) && if_ready;
    w_push       = !redirect_valid && ((r_state != FULL) || w_pop);
    // Tail slot after any pop this edge: count - pop.
    w_wr_slot    = (r_state == FULL) || ((r_state == ONE) && !w_pop);
    w_state_next = r_state;
    w_fpc_next   = r_fpc;
    if (redirect_valid) begin
      w_state_next = EMPTY;
      w_fpc_next   = {redirect_pc[31:2], 2'b00};
    end else begin
      if (w_push) w_fpc_next = r_fpc + 32'd4;
      case (r_state)
        EMPTY: if (w_push) w_state_next = ONE;
        ONE: begin
          if (w_push && !w_pop)      w_state_next = FULL;
          else if (w_pop && !w_push) w_state_next = EMPTY;
        end
        FULL:    if (w_pop && !w_push) w_state_next = ONE;
        default: w_state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_fpc   <= RESET_PC;
    end else begin
      r_state <= w_state_next;
      r_fpc   <= w_fpc_next;
    end
  end

  // Slot 0 is always the head; a pop shifts slot 1 down unless slot 0 is refilled.
  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_pc[gi]    <= 32'h0;
        r_instr[gi] <= 32'h0;
      end else if (!redirect_valid) begin
        if (w_push && (w_wr_slot == 1'(gi))) begin
          r_pc[gi]    <= r_fpc;
          r_instr[gi] <= imem_instr;
        end else if ((gi == 0) && w_pop) begin
          r_pc[gi]    <= r_pc[1];
          r_instr[gi] <= r_instr[1];
        end
      end
    end
  end

  assign imem_addr = r_fpc;
  assign if_valid  = (r_state != EMPTY);
  assign if_pc     = if_valid ? r_pc[0]    : 32'h0;
  assign if_instr  = if_valid ? r_instr[0] : 32'h0;

`ifdef FETCH_PERF_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= 32'h0;
    end else if (if_valid && !if_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule
